dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind the MEM-stage interface, with a fixed wait-state count per access.
// Optional performance counters are enabled by defining DMEM_PERF_CNT_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             din_q, din_d;

  logic [31:0]             ram [0:(1<<ADDR_WIDTH)-1];

  logic                    req, mis, acc, acc_wr;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_data;

  assign req = mem_ren | mem_wen;
  assign mis = req & (mem_addr[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    acc      = 1'b0;
    acc_wr   = wr_q;
    acc_idx  = idx_q;
    acc_data = wdata_q;
    case (state_q)
      IDLE: begin
        if (req && !mis) begin
          wr_d    = mem_wen;
          idx_d   = mem_addr[ADDR_WIDTH+1:2];
          wdata_d = mem_dout;
          cnt_d   = LAT;
          // Zero wait states: the access happens at the sampling edge itself.
          if (LATENCY == 0) begin
            acc      = 1'b1;
            acc_wr   = mem_wen;
            acc_idx  = mem_addr[ADDR_WIDTH+1:2];
            acc_data = mem_dout;
            state_d  = DONE;
          end else begin
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    din_d = din_q;
    if (acc && !acc_wr) din_d = ram[acc_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
    end
  end

  // Array is never cleared; a write caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (acc && acc_wr && !rst) ram[acc_idx] <= acc_data;
  end

  assign mem_din   = din_q;
  assign mem_stall = !rst && ((state_q == IDLE && req && !mis) || state_q == WAIT);
  assign mem_err   = !rst && (state_q == IDLE) && (mis || (mem_ren && mem_wen));

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, st_cnt_q, st_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + {31'd0, acc & ~acc_wr};
    wr_cnt_d = wr_cnt_q + {31'd0, acc & acc_wr};
    st_cnt_d = st_cnt_q + {31'd0, mem_stall};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign perf_rd_cnt    = rd_cnt_q;
  assign perf_wr_cnt    = wr_cnt_q;
  assign perf_stall_cnt = st_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for the main sequence,
// LATENCY=0 instance for address aliasing and minimum occupancy.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        ren, wen, ren0, wen0;
  logic [31:0] addr, dout, addr0, dout0;
  logic [31:0] din, din0;
  logic        stall, err, stall0, err0;
  int          checks = 0;
  int          failures = 0;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] prd, pwr, pst, prd0, pwr0, pst0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
    .mem_dout(dout), .mem_din(din), .mem_stall(stall), .mem_err(err)
`ifdef DMEM_PERF_CNT_EN
    , .perf_rd_cnt(prd), .perf_wr_cnt(pwr), .perf_stall_cnt(pst)
`endif
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_ren(ren0), .mem_wen(wen0), .mem_addr(addr0),
    .mem_dout(dout0), .mem_din(din0), .mem_stall(stall0), .mem_err(err0)
`ifdef DMEM_PERF_CNT_EN
    , .perf_rd_cnt(prd0), .perf_wr_cnt(pwr0), .perf_stall_cnt(pst0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren = r; wen = w; addr = a; dout = d;
  endtask

  // One full LATENCY=2 access: IDLE(stall) WAIT WAIT DONE(no stall).
  task automatic do_acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_din, input string tag);
    step();
    drive(r, w, a, d);
    #1;
    chk({tag, "_req_stall"}, {31'd0, stall}, 32'd1);
    chk({tag, "_req_err"},   {31'd0, err},   {31'd0, exp_err});
    step();
    chk({tag, "_w1_stall"},  {31'd0, stall}, 32'd1);
    chk({tag, "_w1_err"},    {31'd0, err},   32'd0);
    step();
    chk({tag, "_w2_stall"},  {31'd0, stall}, 32'd1);
    step();
    chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_done_din"},   din,            exp_din);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    ren0 = 1'b0; wen0 = 1'b0; addr0 = 32'd0; dout0 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_din",   din,              32'd0);
    chk("rst_stall", {31'd0, stall},   32'd0);
    chk("rst_err",   {31'd0, err},     32'd0);
    chk("rst_din0",  din0,             32'd0);
    rst = 1'b0;

    // write then read back
    do_acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0,        "wr10");
    do_acc(1'b1, 1'b0, 32'h10, 32'd0,        1'b0, 32'hDEADBEEF, "rd10");

    // preload then back-to-back reads
    do_acc(1'b0, 1'b1, 32'h10, 32'h11111111, 1'b0, 32'hDEADBEEF, "pl10");
    do_acc(1'b0, 1'b1, 32'h14, 32'h22222222, 1'b0, 32'hDEADBEEF, "pl14");
    do_acc(1'b1, 1'b0, 32'h10, 32'd0,        1'b0, 32'h11111111, "b2b10");
    do_acc(1'b1, 1'b0, 32'h14, 32'd0,        1'b0, 32'h22222222, "b2b14");

    // misaligned read
    step();
    drive(1'b1, 1'b0, 32'h13, 32'd0);
    #1;
    chk("mis_err",   {31'd0, err},   32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("mis_err_gone", {31'd0, err},   32'd0);
    chk("mis_din",      din,            32'h22222222);

    // read+write together acts as a write
    do_acc(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 32'h22222222, "rw20");
    do_acc(1'b1, 1'b0, 32'h20, 32'd0,        1'b0, 32'hCAFEF00D, "rd20");

    // reset during a pending write
    do_acc(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 32'hCAFEF00D, "pl30");
    step();
    drive(1'b0, 1'b1, 32'h30, 32'h12345678);
    #1;
    chk("rstw_req_stall", {31'd0, stall}, 32'd1);
    step();
    chk("rstw_wait_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("rstw_stall", {31'd0, stall}, 32'd0);
    chk("rstw_din",   din,            32'd0);
    step();
    rst = 1'b0;
    do_acc(1'b1, 1'b0, 32'h30, 32'd0, 1'b0, 32'hA5A5A5A5, "rd30");

    // LATENCY=0 instance: 0x1000 aliases word 0
    step();
    wen0 = 1'b1; addr0 = 32'h1000; dout0 = 32'h0BADF00D;
    #1;
    chk("l0_wr_stall", {31'd0, stall0}, 32'd1);
    step();
    chk("l0_wr_done_stall", {31'd0, stall0}, 32'd0);
    wen0 = 1'b0; addr0 = 32'd0; dout0 = 32'd0;
    step();
    ren0 = 1'b1; addr0 = 32'h0;
    #1;
    chk("l0_rd_stall", {31'd0, stall0}, 32'd1);
    step();
    chk("l0_rd_done_stall", {31'd0, stall0}, 32'd0);
    chk("l0_rd_din",        din0,             32'h0BADF00D);
    ren0 = 1'b0;
`ifdef DMEM_PERF_CNT_EN
    step();
    chk("l0_perf_rd",    prd0, 32'd1);
    chk("l0_perf_wr",    pwr0, 32'd1);
    chk("l0_perf_stall", pst0, 32'd2);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
